// File: rtl/push_engine_if.sv
// push_engine_if: level-load, move-request, status and GRAM port bundle (master = controller/GRAM side, slave = engine)
interface push_engine_if;
  logic load;
  logic [4:0] px_init;
  logic [3:0] py_init;
  logic [7:0] boxes_init;
  logic dir_valid;
  logic [1:0] dir;
  logic [3:0] GData_out;
  logic [8:0] GAddr_w;
  logic Grea;
  logic Gwea;
  logic [3:0] GData_in;
  logic busy;
  logic moved;
  logic blocked;
  logic [15:0] step_count;
  logic win;
  modport master(output load, px_init, py_init, boxes_init, dir_valid, dir, GData_out,
                 input GAddr_w, Grea, Gwea, GData_in, busy, moved, blocked, step_count, win);
  modport slave(input load, px_init, py_init, boxes_init, dir_valid, dir, GData_out,
                output GAddr_w, Grea, Gwea, GData_in, busy, moved, blocked, step_count, win);
endinterface

// File: rtl/push_engine.sv
// push_engine: Sokoban move engine on a 20x15 GRAM (clk, async rst, bus: load/dir requests in, GRAM access and moved/blocked/step_count/win out)
module push_engine (
  input logic clk,
  input logic rst,
  push_engine_if.slave bus
);
  typedef enum logic [3:0] {IDLE, RD1, RD2, RD3, DEC, WP, WN, WNN, DONE} state_t;
  state_t state, nxt;
  logic [4:0] px, n1x, n2x;
  logic [3:0] py, n1y, n2y, t1, t2;
  logic [7:0] box_left;
  logic [15:0] steps;
  logic [1:0] dir_r, d;
  logic on_goal, ok, loaded, n1_off, n2_off, push, walk, free2;
  logic [8:0] a1, a2, ap;
  function automatic logic [8:0] addr(input logic [4:0] x, input logic [3:0] y);
    return 9'(y) * 9'd20 + 9'(x);
  endfunction
  always_comb begin
    d = state == IDLE ? bus.dir : dir_r;
    n1x = d == 2'd2 ? px - 5'd1 : d == 2'd3 ? px + 5'd1 : px;
    n2x = d == 2'd2 ? px - 5'd2 : d == 2'd3 ? px + 5'd2 : px;
    n1y = d == 2'd0 ? py - 4'd1 : d == 2'd1 ? py + 4'd1 : py;
    n2y = d == 2'd0 ? py - 4'd2 : d == 2'd1 ? py + 4'd2 : py;
    n1_off = d == 2'd0 ? py == 4'd0 : d == 2'd1 ? py == 4'd14 : d == 2'd2 ? px == 5'd0 : px == 5'd19;
    n2_off = d == 2'd0 ? py < 4'd2 : d == 2'd1 ? py > 4'd12 : d == 2'd2 ? px < 5'd2 : px > 5'd17;
    a1 = addr(n1x, n1y);
    a2 = addr(n2x, n2y);
    ap = addr(px, py);
    walk = t1 == 4'd0 || t1 == 4'd2;
    push = t1 == 4'd3 || t1 == 4'd4;
    free2 = t2 == 4'd0 || t2 == 4'd2;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = bus.load ? IDLE : bus.dir_valid ? (n1_off ? DONE : RD1) : IDLE;
      RD1: nxt = RD2;
      RD2: nxt = RD3;
      RD3: nxt = DEC;
      DEC: nxt = walk || (push && free2) ? WP : DONE;
      WP: nxt = WN;
      WN: nxt = push ? WNN : DONE;
      WNN: nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  // In WNN the player already stands on N1, so the box target (old N2) is the new N1.
  always_comb begin
    bus.busy = state != IDLE;
    bus.Grea = state == RD1 || (state == RD2 && !n2_off);
    bus.Gwea = state == WP || state == WN || state == WNN;
    bus.GAddr_w = state == RD1 || state == WN || state == WNN ? a1 :
                  state == RD2 && !n2_off ? a2 : state == WP ? ap : 9'd0;
    bus.GData_in = state == WP ? (on_goal ? 4'd2 : 4'd0) :
                   state == WN ? (t1 == 4'd2 || t1 == 4'd4 ? 4'd6 : 4'd5) :
                   state == WNN ? (t2 == 4'd2 ? 4'd4 : 4'd3) : 4'd0;
    bus.moved = state == DONE && ok;
    bus.blocked = state == DONE && !ok;
    bus.step_count = steps;
    bus.win = loaded && box_left == 8'd0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      px <= '0;
      py <= '0;
      box_left <= '0;
      steps <= '0;
      on_goal <= 1'b0;
      loaded <= 1'b0;
      ok <= 1'b0;
      dir_r <= '0;
      t1 <= '0;
      t2 <= '0;
    end else begin
      if (state == IDLE && bus.load) begin
        px <= bus.px_init;
        py <= bus.py_init;
        box_left <= bus.boxes_init;
        steps <= '0;
        on_goal <= 1'b0;
        loaded <= 1'b1;
      end else if (state == IDLE && bus.dir_valid) begin
        dir_r <= bus.dir;
        ok <= 1'b0;
      end
      if (state == RD2) t1 <= bus.GData_out;
      if (state == RD3) t2 <= n2_off ? 4'd1 : bus.GData_out;
      if (state == WN) begin
        px <= n1x;
        py <= n1y;
        on_goal <= t1 == 4'd2 || t1 == 4'd4;
        ok <= 1'b1;
      end
      if (state == WNN)
        box_left <= t1 == 4'd3 && t2 == 4'd2 && box_left != 8'd0 ? box_left - 8'd1 :
                    t1 == 4'd4 && t2 == 4'd0 && box_left != 8'd255 ? box_left + 8'd1 : box_left;
      if (state == DONE && ok) steps <= steps + 16'd1;
    end
endmodule

// File: tb/tb_push_engine.sv
// tb_push_engine: directed Sokoban moves checked against a game-level model of the grid
module tb_push_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  push_engine_if bus();
  push_engine dut (.clk(clk), .rst(rst), .bus(bus));
  logic [3:0] gram [0:511];
  logic [3:0] mg [0:299];
  int mpx, mpy, mbl, msteps;
  bit mog, mloaded;
  int errors = 0;
  int checks = 0;
  always @(posedge clk) begin
    if (bus.Grea) bus.GData_out <= gram[bus.GAddr_w];
    if (bus.Gwea) gram[bus.GAddr_w] <= bus.GData_in;
  end
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic clr();
    for (int i = 0; i < 512; i++) gram[i] <= 4'd0;
    for (int i = 0; i < 300; i++) mg[i] = 4'd0;
  endtask
  task automatic put(input int x, input int y, input int t);
    gram[y * 20 + x] <= 4'(t);
    mg[y * 20 + x] = 4'(t);
  endtask
  task automatic load_lvl(input int x, input int y, input int b);
    @(negedge clk);
    bus.px_init = 5'(x);
    bus.py_init = 4'(y);
    bus.boxes_init = 8'(b);
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    mpx = x; mpy = y; mbl = b; msteps = 0; mog = 0; mloaded = 1;
    chk("load_steps", int'(bus.step_count), 0);
    chk("load_win", int'(bus.win), int'(b == 0));
    chk("load_busy", int'(bus.busy), 0);
  endtask
  task automatic move(input logic [1:0] d, input bit poke);
    int dx, dy, n1x, n1y, n2x, n2y, p, a1, a2, t1, t2, lat, bad;
    bit ok, isp, done;
    int wa[$];
    int wd[$];
    dx = d == 2'd2 ? -1 : d == 2'd3 ? 1 : 0;
    dy = d == 2'd0 ? -1 : d == 2'd1 ? 1 : 0;
    n1x = mpx + dx; n1y = mpy + dy;
    n2x = mpx + 2 * dx; n2y = mpy + 2 * dy;
    p = mpy * 20 + mpx;
    a1 = n1y * 20 + n1x;
    a2 = n2y * 20 + n2x;
    ok = 0; isp = 0; t1 = 0; t2 = 1;
    if (n1x < 0 || n1x > 19 || n1y < 0 || n1y > 14) lat = 1;
    else begin
      t1 = int'(mg[a1]);
      if (!(n2x < 0 || n2x > 19 || n2y < 0 || n2y > 14)) t2 = int'(mg[a2]);
      if (t1 == 0 || t1 == 2) begin ok = 1; lat = 7; end
      else if ((t1 == 3 || t1 == 4) && (t2 == 0 || t2 == 2)) begin ok = 1; isp = 1; lat = 8; end
      else lat = 5;
    end
    if (ok) begin
      wa.push_back(p); wd.push_back(mog ? 2 : 0);
      wa.push_back(a1); wd.push_back(t1 == 2 || t1 == 4 ? 6 : 5);
      if (isp) begin
        wa.push_back(a2); wd.push_back(t2 == 2 ? 4 : 3);
        if (t1 == 3 && t2 == 2 && mbl > 0) mbl--;
        if (t1 == 4 && t2 == 0 && mbl < 255) mbl++;
      end
      foreach (wa[i]) mg[wa[i]] = 4'(wd[i]);
      mog = t1 == 2 || t1 == 4;
      mpx = n1x; mpy = n1y;
      msteps = (msteps + 1) % 65536;
    end
    @(negedge clk);
    bus.dir = d;
    bus.dir_valid = 1'b1;
    done = 0;
    for (int c = 1; c <= 12 && !done; c++) begin
      @(negedge clk);
      bus.dir_valid = poke && c < 4;
      bus.dir = ~d;
      bus.load = poke && c == 2;
      chk("excl", int'(bus.Grea & bus.Gwea), 0);
      chk("busy", int'(bus.busy), 1);
      if (lat == 1) chk("grea_offgrid", int'(bus.Grea), 0);
      if (bus.Gwea) begin
        if (wa.size() == 0) chk("extra_write", int'(bus.GAddr_w), -1);
        else begin
          chk("waddr", int'(bus.GAddr_w), wa[0]);
          chk("wdata", int'(bus.GData_in), wd[0]);
          void'(wa.pop_front());
          void'(wd.pop_front());
        end
      end
      if (bus.moved || bus.blocked) begin
        done = 1;
        chk("latency", c, lat);
        chk("moved", int'(bus.moved), int'(ok));
        chk("blocked", int'(bus.blocked), int'(!ok));
      end
    end
    bus.dir_valid = 1'b0;
    bus.load = 1'b0;
    if (!done) chk("timeout", 0, 1);
    chk("writes_left", wa.size(), 0);
    @(negedge clk);
    chk("idle", int'(bus.busy), 0);
    chk("steps", int'(bus.step_count), msteps);
    chk("win", int'(bus.win), int'(mloaded && mbl == 0));
    bad = 0;
    for (int i = 0; i < 300; i++) if (gram[i] !== mg[i]) bad++;
    chk("grid", bad, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bus.load = 1'b0; bus.px_init = '0; bus.py_init = '0; bus.boxes_init = '0;
    bus.dir_valid = 1'b0; bus.dir = '0; bus.GData_out <= '0;
    clr();
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_rw", int'(bus.Grea | bus.Gwea), 0);
    chk("rst_out", int'(bus.moved | bus.blocked | bus.win), 0);
    chk("rst_steps", int'(bus.step_count), 0);
    chk("rst_addr", int'(bus.GAddr_w), 0);
    rst = 1'b0;
    // walk right onto floor
    clr(); put(3, 3, 5); load_lvl(3, 3, 0);
    move(2'd3, 0);
    chk("lit_walk_steps", int'(bus.step_count), 1);
    chk("lit_walk_g63", int'(gram[63]), 0);
    chk("lit_walk_g64", int'(gram[64]), 5);
    // push box onto goal
    clr(); put(3, 3, 5); put(4, 3, 3); put(5, 3, 2); load_lvl(3, 3, 1);
    move(2'd3, 1);
    chk("lit_push_g65", int'(gram[65]), 4);
    chk("lit_push_win", int'(bus.win), 1);
    // blocked: wall, code 9, box behind box
    clr(); put(3, 3, 5); put(4, 3, 1); load_lvl(3, 3, 0);
    move(2'd3, 0);
    put(4, 3, 9); move(2'd3, 0);
    put(4, 3, 3); put(5, 3, 3); move(2'd3, 0);
    chk("lit_blocked_steps", int'(bus.step_count), 0);
    // off-grid N1 and off-grid N2
    clr(); put(0, 0, 5); load_lvl(0, 0, 0);
    move(2'd0, 0);
    move(2'd2, 0);
    clr(); put(18, 0, 5); put(19, 0, 3); load_lvl(18, 0, 2);
    move(2'd3, 0);
    // box leaves goal, then player leaves goal
    clr(); put(3, 3, 5); put(4, 3, 4); load_lvl(3, 3, 0);
    move(2'd3, 0);
    chk("lit_boxoff_win", int'(bus.win), 0);
    move(2'd2, 0);
    chk("lit_goalexit_g64", int'(gram[64]), 2);
    // push down onto goal
    clr(); put(5, 5, 5); put(5, 6, 3); put(5, 7, 2); load_lvl(5, 5, 1);
    move(2'd1, 1);
    move(2'd0, 0);
    // box_left saturates at 0
    clr(); put(3, 3, 5); put(4, 3, 3); put(5, 3, 2); load_lvl(3, 3, 0);
    move(2'd3, 0);
    chk("lit_sat0_win", int'(bus.win), 1);
    // goal exit with busy-time pokes
    clr(); put(3, 2, 5); put(2, 2, 2); load_lvl(3, 2, 0);
    move(2'd2, 1);
    move(2'd2, 1);
    chk("lit_exit_g42", int'(gram[42]), 2);
    chk("lit_exit_g41", int'(gram[41]), 5);
    chk("lit_exit_steps", int'(bus.step_count), 2);
    // reset while in WN
    @(negedge clk);
    bus.dir = 2'd2;
    bus.dir_valid = 1'b1;
    @(negedge clk);
    bus.dir_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("wn_gwea", int'(bus.Gwea), 1);
    chk("wn_addr", int'(bus.GAddr_w), 40);
    rst = 1'b1;
    #1;
    chk("rstwn_gwea", int'(bus.Gwea), 0);
    chk("rstwn_busy", int'(bus.busy), 0);
    chk("rstwn_steps", int'(bus.step_count), 0);
    chk("rstwn_win", int'(bus.win), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstwn_nowrite", int'(gram[40]), 0);
    chk("rstwn_idle", int'(bus.busy | bus.Gwea | bus.Grea), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/push_engine.md
PUSH_ENGINE -- requirements
Module: push_engine

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset; asynchronous, active-high.
REQ-003 load  input  1  one-cycle pulse; loads level start state.
REQ-004 px_init  input  5  player start column (0..19).
REQ-005 py_init  input  4  player start row (0..14).
REQ-006 boxes_init  input  8  number of boxes not on goals at level start.
REQ-007 dir_valid  input  1  one-cycle move request.
REQ-008 dir  input  2  direction: 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1).
REQ-009 GData_out  input  4  tile read from GRAM; valid one cycle after the address is driven with Grea=1.
REQ-010 GAddr_w  output  9  GRAM address = y*20 + x.
REQ-011 Grea  output  1  GRAM read enable.
REQ-012 Gwea  output  1  GRAM write enable.
REQ-013 GData_in  output  4  tile written to GRAM.
REQ-014 busy  output  1  high while a move is processed.
REQ-015 moved / blocked  output  1 each  one-cycle result pulses.
REQ-016 step_count  output  16  accepted moves since load.
REQ-017 win  output  1  high when the box_left counter equals 0 after a load.

Function
REQ-018 Tile codes SHALL be: 0 floor, 1 wall, 2 goal, 3 box, 4 box-on-goal, 5 player, 6 player-on-goal; codes 7..15 SHALL be treated as wall.
REQ-019 Grid SHALL be 20 x 15; x in 0..19, y in 0..14; address arithmetic SHALL be 9-bit unsigned.
REQ-020 Registers: px, py, box_left (8 bits), step_count; FSM states IDLE, RD1, RD2, RD3, DEC, WP, WN, WNN, DONE.
REQ-021 IDLE: load SHALL set px/py from init inputs, box_left to boxes_init, step_count to 0; load has priority over dir_valid; load outside IDLE SHALL be ignored.
REQ-022 IDLE with dir_valid: compute N1 (neighbour) and N2 (two cells away); if N1 is off-grid -> DONE with blocked=1 and no GRAM access; else -> RD1.
REQ-023 RD1: Grea=1, GAddr_w=N1 -> RD2.
REQ-024 RD2: Grea=1, GAddr_w=N2 (if N2 is off-grid, no read and t2 forced to 1); capture t1=GData_out -> RD3.
REQ-025 RD3: capture t2 (unless forced) -> DEC; Grea=0.
REQ-026 DEC: t1 in {0,2} -> WP (walk); t1 in {3,4} and t2 in {0,2} -> WP (push); otherwise -> DONE with blocked.
REQ-027 WP: Gwea=1, address = player cell, data = 2 if the player cell is on a goal, else 0 -> WN.
REQ-028 WN: Gwea=1, address=N1, data = 6 if t1 in {2,4}, else 5; px/py update to N1 -> WNN if push, else DONE.
REQ-029 WNN: Gwea=1, address=N2, data = 4 if t2=2, else 3 -> DONE.
REQ-030 The engine SHALL track "player on goal" in a register: set from t1 at WN, cleared on load.
REQ-031 box_left SHALL decrement when a box moves from t1=3 onto t2=2, increment when it moves from t1=4 onto t2=0, and otherwise stay unchanged; it SHALL saturate at 0 and 255.
REQ-032 DONE: exactly one of moved/blocked SHALL be high for one cycle; step_count += 1 on moved, wrapping 65535->0 -> IDLE.
REQ-033 busy SHALL be high in every state except IDLE; dir_valid SHALL be ignored while busy.
REQ-034 Grea and Gwea SHALL never be high in the same cycle; both SHALL be 0 in IDLE, DEC and DONE.
REQ-035 Latency, with dir_valid at cycle 0: push -> moved at cycle 8; walk -> moved at cycle 7; wall-blocked -> blocked at cycle 5; off-grid -> blocked at cycle 1.

Reset
REQ-036 rst SHALL force IDLE, px=py=0, box_left=0, step_count=0, player-on-goal flag=0, and all outputs to 0 (win=0 until the first load), aborting any move mid-sequence with no further GRAM writes.

Verification
REQ-037 Walk: load (3,3), tiles (4,3)=0; right -> writes addr 63=0, then addr 64=5; moved at cycle 7; step_count=1.
REQ-038 Push onto goal: boxes_init=1, (4,3)=3, (5,3)=2; right -> writes 63=0, 64=5, 65=4; box_left=0; win=1.
REQ-039 Blocked: (4,3)=1; right -> no Gwea; blocked at cycle 5; step_count unchanged; box behind box -> blocked.
REQ-040 Edge: player at (0,0), up -> blocked at cycle 1 with Grea=0; player at (18,0), box at (19,0), right -> N2 off-grid, blocked.
REQ-041 Goal exit: player on goal at (2,2), walk left -> writes 42=2, 41=5; dir_valid pulses during busy are ignored.
REQ-042 Reset in WN -> next cycle IDLE, Gwea=0, busy=0, step_count=0.
